// File: rtl/csr_file_if.sv
// CSR access port between the instruction decoder (master) and the CSR file (slave).
// Read data is combinational; writes commit on the next clock edge.
interface csr_if;
  logic        csr_en;
  logic [11:0] csr_addr;
  logic        csr_we;
  logic [31:0] csr_wd;
  logic [31:0] csr_rd;
  logic        csr_illegal;

  modport master (output csr_en, csr_addr, csr_we, csr_wd, input csr_rd, csr_illegal);
  modport slave  (input csr_en, csr_addr, csr_we, csr_wd, output csr_rd, csr_illegal);
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file for the single-cycle RV32I core: combinational read,
// edge-committed write, 64-bit cycle/instret counters, trap entry and mret side-effects.
module csr_file #(
  parameter logic [31:0] HART_ID = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  csr_if.slave        csr,
  input  logic        instret_inc,
  input  logic        trap_valid,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic        mret,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic        mie_global
);
  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;
  localparam logic [31:0] MISA_VAL    = 32'h4000_0100;

  logic        st_mie, st_mpie;
  logic [2:0]  mie_bits;          // mie[11], mie[7], mie[3]
  logic [31:0] mtvec, mscratch, mepc, mcause;
  logic [63:0] mcycle, minstret;

  // Trap entry blocks every CSR write in its cycle.
  logic wr;
  assign wr = csr.csr_en & csr.csr_we & ~trap_valid;

  logic wr_cyc_lo, wr_cyc_hi, wr_ins_lo, wr_ins_hi;
  assign wr_cyc_lo = wr && (csr.csr_addr == A_MCYCLE);
  assign wr_cyc_hi = wr && (csr.csr_addr == A_MCYCLEH);
  assign wr_ins_lo = wr && (csr.csr_addr == A_MINSTRET);
  assign wr_ins_hi = wr && (csr.csr_addr == A_MINSTRETH);

  logic [31:0] mstatus_rd;
  assign mstatus_rd = {19'd0, 2'b11, 3'd0, st_mpie, 3'd0, st_mie, 3'd0};

  logic [31:0] rd;
  logic        impl;
  always_comb begin
    rd   = '0;
    impl = 1'b1;
    case (csr.csr_addr)
      A_MSTATUS:               rd = mstatus_rd;
      A_MISA:                  rd = MISA_VAL;
      A_MIE:                   rd = {20'd0, mie_bits[2], 3'd0, mie_bits[1], 3'd0, mie_bits[0], 3'd0};
      A_MTVEC:                 rd = mtvec;
      A_MSCRATCH:              rd = mscratch;
      A_MEPC:                  rd = mepc;
      A_MCAUSE:                rd = mcause;
      A_MIP:                   rd = '0;
      A_MCYCLE,   A_CYCLE:     rd = mcycle[31:0];
      A_MCYCLEH,  A_CYCLEH:    rd = mcycle[63:32];
      A_MINSTRET, A_INSTRET:   rd = minstret[31:0];
      A_MINSTRETH, A_INSTRETH: rd = minstret[63:32];
      A_MHARTID:               rd = HART_ID;
      default:                 impl = 1'b0;
    endcase
  end

  assign csr.csr_rd      = rd;
  assign csr.csr_illegal = csr.csr_en & ~impl;
  assign mtvec_o         = mtvec;
  assign mepc_o          = mepc;
  assign mie_global      = st_mie;

  // mstatus: trap > mret > write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_mie  <= 1'b0;
      st_mpie <= 1'b0;
    end else if (trap_valid) begin
      st_mpie <= st_mie;
      st_mie  <= 1'b0;
    end else if (mret) begin
      st_mie  <= st_mpie;
      st_mpie <= 1'b1;
    end else if (wr && csr.csr_addr == A_MSTATUS) begin
      st_mie  <= csr.csr_wd[3];
      st_mpie <= csr.csr_wd[7];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_bits <= '0;
      mtvec    <= '0;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
    end else if (trap_valid) begin
      mepc   <= trap_pc & ~32'd3;
      mcause <= trap_cause;
    end else if (wr) begin
      case (csr.csr_addr)
        A_MIE:      mie_bits <= {csr.csr_wd[11], csr.csr_wd[7], csr.csr_wd[3]};
        A_MTVEC:    mtvec    <= csr.csr_wd & ~32'd3;
        A_MSCRATCH: mscratch <= csr.csr_wd;
        A_MEPC:     mepc     <= csr.csr_wd & ~32'd3;
        A_MCAUSE:   mcause   <= csr.csr_wd;
        default:    ;
      endcase
    end
  end

  // A write to either half loads it and freezes the whole counter for the cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      if (wr_cyc_lo)      mcycle[31:0]  <= csr.csr_wd;
      else if (wr_cyc_hi) mcycle[63:32] <= csr.csr_wd;
      else                mcycle        <= mcycle + 64'd1;

      if (wr_ins_lo)        minstret[31:0]  <= csr.csr_wd;
      else if (wr_ins_hi)   minstret[63:32] <= csr.csr_wd;
      else if (instret_inc) minstret        <= minstret + 64'd1;
    end
  end
endmodule

// File: tb/tb_csr_file.sv
// Randomized check of csr_file against a table-driven CSR model, plus directed
// scenarios for counters, trap/mret, illegal addresses and async reset.
module tb_csr_file;
  localparam logic [31:0] HID = 32'd5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instret_inc = 1'b0, trap_valid = 1'b0, mret = 1'b0;
  logic [31:0] trap_cause = '0, trap_pc = '0;
  logic [31:0] mtvec_o, mepc_o;
  logic        mie_global;

  csr_if io();

  csr_file #(.HART_ID(HID)) dut (
    .clk(clk), .rst_n(rst_n), .csr(io),
    .instret_inc(instret_inc), .trap_valid(trap_valid), .trap_cause(trap_cause),
    .trap_pc(trap_pc), .mret(mret), .mtvec_o(mtvec_o), .mepc_o(mepc_o),
    .mie_global(mie_global)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---- reference model: plain storage of architectural CSR values ----
  logic [31:0] m_reg [logic [11:0]];
  logic [63:0] m_cyc, m_ins;

  function automatic logic [31:0] wmask(input logic [11:0] a);
    case (a)
      12'h300:          return 32'h0000_0088;
      12'h304:          return 32'h0000_0888;
      12'h305, 12'h341: return 32'hFFFF_FFFC;
      12'h340, 12'h342: return 32'hFFFF_FFFF;
      default:          return 32'h0;
    endcase
  endfunction

  function automatic bit m_impl(input logic [11:0] a);
    return a inside {12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                     12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
                     12'hC02, 12'hC82, 12'hF14};
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300:                   return m_reg[12'h300] | 32'h0000_1800;
      12'h301:                   return 32'h4000_0100;
      12'h304, 12'h305, 12'h340,
      12'h341, 12'h342:          return m_reg[a];
      12'hB00, 12'hC00:          return m_cyc[31:0];
      12'hB80, 12'hC80:          return m_cyc[63:32];
      12'hB02, 12'hC02:          return m_ins[31:0];
      12'hB82, 12'hC82:          return m_ins[63:32];
      12'hF14:                   return HID;
      default:                   return 32'h0;
    endcase
  endfunction

  task automatic m_reset();
    m_reg[12'h300] = 0; m_reg[12'h304] = 0; m_reg[12'h305] = 0;
    m_reg[12'h340] = 0; m_reg[12'h341] = 0; m_reg[12'h342] = 0;
    m_cyc = 0; m_ins = 0;
  endtask

  task automatic m_update();
    bit          wr, cyc_ld, ins_ld, old_mie, old_mpie;
    logic [11:0] a;
    wr = io.csr_en && io.csr_we && !trap_valid;
    a  = io.csr_addr;
    cyc_ld = 0; ins_ld = 0;
    old_mie  = m_reg[12'h300][3];
    old_mpie = m_reg[12'h300][7];
    if (wr) begin
      if (wmask(a) != 0 && !(a == 12'h300 && mret)) m_reg[a] = io.csr_wd & wmask(a);
      case (a)
        12'hB00: begin m_cyc = {m_cyc[63:32], io.csr_wd}; cyc_ld = 1; end
        12'hB80: begin m_cyc = {io.csr_wd, m_cyc[31:0]};  cyc_ld = 1; end
        12'hB02: begin m_ins = {m_ins[63:32], io.csr_wd}; ins_ld = 1; end
        12'hB82: begin m_ins = {io.csr_wd, m_ins[31:0]};  ins_ld = 1; end
        default: ;
      endcase
    end
    if (!cyc_ld) m_cyc = m_cyc + 1;
    if (!ins_ld && instret_inc) m_ins = m_ins + 1;
    if (trap_valid) begin
      m_reg[12'h341] = trap_pc & ~32'd3;
      m_reg[12'h342] = trap_cause;
      m_reg[12'h300] = old_mie ? 32'h80 : 32'h0;
    end else if (mret) begin
      m_reg[12'h300] = 32'h80 | (old_mpie ? 32'h8 : 32'h0);
    end
  endtask

  // Drive one cycle (called just after a rising edge), check outputs mid-cycle,
  // then advance the model across the next edge.
  task automatic step(input logic en, input logic [11:0] a, input logic we, input logic [31:0] wd,
                      input logic inc, input logic trap, input logic [31:0] cause,
                      input logic [31:0] pc, input logic mr, output logic [31:0] rdv);
    io.csr_en = en; io.csr_addr = a; io.csr_we = we; io.csr_wd = wd;
    instret_inc = inc; trap_valid = trap; trap_cause = cause; trap_pc = pc; mret = mr;
    #2;
    rdv = io.csr_rd;
    chk($sformatf("rd[%h]", a), io.csr_rd, m_read(a));
    chk($sformatf("illegal[%h]", a), io.csr_illegal, en && !m_impl(a));
    chk("mtvec_o", mtvec_o, m_reg[12'h305]);
    chk("mepc_o", mepc_o, m_reg[12'h341]);
    chk("mie_global", mie_global, m_reg[12'h300][3]);
    @(posedge clk);
    m_update();
    #1;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] v);
    step(1, a, 0, 0, 0, 0, 0, 0, 0, v);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    logic [31:0] v;
    step(1, a, 1, d, 0, 0, 0, 0, 0, v);
  endtask

  logic [11:0] addrs [20] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                              12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
                              12'hC02, 12'hC82, 12'hF14, 12'h7C0, 12'h000, 12'h345};

  initial begin
    logic [31:0] v;
    io.csr_en = 0; io.csr_addr = 12'h340; io.csr_we = 0; io.csr_wd = 0;
    m_reset();
    #2;
    chk("rst mie_global", mie_global, 1'b0);
    chk("rst mtvec_o", mtvec_o, 32'h0);
    chk("rst mepc_o", mepc_o, 32'h0);
    chk("rst mscratch", io.csr_rd, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // idle counters
    for (int i = 0; i < 5; i++) begin
      rd(12'hB00, v);
      chk("mcycle idle", v, 32'(i));
    end
    rd(12'hB02, v); chk("minstret idle", v, 32'h0);
    rd(12'h301, v); chk("misa", v, 32'h4000_0100);
    rd(12'hF14, v); chk("mhartid", v, HID);

    // WARL fields
    wr(12'h305, 32'h8000_0007);
    rd(12'h305, v); chk("mtvec_o align", mtvec_o, 32'h8000_0004);
    wr(12'h300, 32'hFFFF_FFFF);
    rd(12'h300, v); chk("mstatus mask", v, 32'h0000_1888);

    // counter carry
    wr(12'hB00, 32'hFFFF_FFFE);
    wr(12'hB80, 32'd5);
    rd(12'hB00, v); chk("mcycle held", v, 32'hFFFF_FFFE);
    rd(12'hB00, v); chk("mcycle lo max", v, 32'hFFFF_FFFF);
    rd(12'hB80, v); chk("mcycleh carry", v, 32'd6);

    // trap entry wins over a concurrent write, then mret
    wr(12'h300, 32'h8);
    step(1, 12'h340, 1, 32'hDEAD_BEEF, 0, 1, 32'd11, 32'h102, 0, v);
    rd(12'h341, v); chk("trap mepc", mepc_o, 32'h100);
    rd(12'h342, v); chk("trap mcause", v, 32'd11);
    rd(12'h300, v); chk("trap mstatus", v, 32'h0000_1880);
    rd(12'h340, v);
    step(1, 12'h300, 1, 32'h0, 0, 0, 0, 0, 1, v);
    rd(12'h300, v); chk("mret mstatus", v, 32'h0000_1888);

    // illegal vs read-only
    rd(12'h7C0, v); chk("illegal rd", v, 32'h0);
    step(1, 12'h7C0, 0, 0, 0, 0, 0, 0, 0, v);
    wr(12'hC00, 32'h1234);
    rd(12'hC00, v);

    // instret with a load during a pulse
    step(1, 12'hB02, 1, 32'd100, 1, 0, 0, 0, 0, v);
    step(0, 12'h000, 0, 0, 0, 0, 0, 0, 0, v);
    step(0, 12'h000, 0, 0, 1, 0, 0, 0, 0, v);
    step(0, 12'h000, 0, 0, 0, 0, 0, 0, 0, v);
    step(0, 12'h000, 0, 0, 1, 0, 0, 0, 0, v);
    rd(12'hB02, v); chk("minstret count", v, 32'd102);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [11:0] a;
      logic        trap, mr;
      a    = addrs[$urandom_range(19)];
      trap = ($urandom_range(15) == 0);
      mr   = ($urandom_range(11) == 0);
      step($urandom_range(3) != 0, a, $urandom_range(1) == 1,
           ($urandom_range(7) == 0) ? 32'hFFFF_FFFF - $urandom_range(3) : $urandom(),
           $urandom_range(1) == 1, trap, $urandom(), $urandom(), mr, v);
    end

    // asynchronous reset in mid-cycle discards a pending write
    io.csr_en = 1; io.csr_addr = 12'h340; io.csr_we = 1; io.csr_wd = 32'hA5A5_A5A5;
    trap_valid = 1; trap_pc = 32'h40; instret_inc = 0; mret = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst mscratch", io.csr_rd, 32'h0);
    chk("arst mie_global", mie_global, 1'b0);
    chk("arst mepc_o", mepc_o, 32'h0);
    chk("arst mtvec_o", mtvec_o, 32'h0);
    @(posedge clk); #1;
    io.csr_en = 0; io.csr_we = 0; trap_valid = 0;
    #3 rst_n = 1'b1;
    m_reset();
    rd(12'hB00, v); chk("post-rst mcycle0", v, 32'h0);
    rd(12'hB00, v); chk("post-rst mcycle1", v, 32'h1);
    rd(12'h340, v); chk("post-rst mscratch", v, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
